// File: rtl/exc_info_gen.sv
// MEM-stage exception packer: classifies two issuing slots by MIPS priority for CP0.
// Latency: every output is registered, 1 cycle after the accepted inputs.
// Backpressure: stall_i or a flush/squash window gives a bubble; no input is consumed.
module exc_info_gen #(
  parameter int EXCEPTINFO_WD = 16,
  parameter int FLUSH_CYCLES  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic                     valid_i1,
  input  logic                     valid_i2,
  input  logic [31:0]              pc_i1,
  input  logic [31:0]              pc_i2,
  input  logic                     is_branch_i1,
  input  logic                     is_branch_i2,
  input  logic                     syscall_i1,
  input  logic                     syscall_i2,
  input  logic                     break_i1,
  input  logic                     break_i2,
  input  logic                     invalid_i1,
  input  logic                     invalid_i2,
  input  logic                     eret_i1,
  input  logic                     eret_i2,
  input  logic                     mfc0_i1,
  input  logic                     mfc0_i2,
  input  logic                     mtc0_i1,
  input  logic                     mtc0_i2,
  input  logic [4:0]               cp0_addr_i1,
  input  logic [4:0]               cp0_addr_i2,
  input  logic                     overflow_i1,
  input  logic                     overflow_i2,
  input  logic                     mem_load_i1,
  input  logic                     mem_load_i2,
  input  logic                     mem_store_i1,
  input  logic                     mem_store_i2,
  input  logic [1:0]               mem_size_i1,
  input  logic [1:0]               mem_size_i2,
  input  logic [31:0]              mem_addr_i1,
  input  logic [31:0]              mem_addr_i2,
  input  logic [31:0]              rt_rdata_i1,
  input  logic [31:0]              rt_rdata_i2,
  output logic [EXCEPTINFO_WD-1:0] exceptinfo_o1,
  output logic [EXCEPTINFO_WD-1:0] exceptinfo_o2,
  output logic [31:0]              current_pc_o1,
  output logic [31:0]              current_pc_o2,
  output logic [31:0]              rt_rdata_o1,
  output logic [31:0]              rt_rdata_o2,
  output logic [31:0]              bad_addr_o1,
  output logic [31:0]              bad_addr_o2,
  output logic                     commit_o1,
  output logic                     commit_o2
);

  typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

  typedef struct packed {
    logic [EXCEPTINFO_WD-1:0] info;
    logic [31:0]              bad;
    logic                     exc;
    logic                     eret;
  } slot_res_t;

  localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_CYCLES);

  // Builds one slot's exceptinfo word; the if-chain order is the exception priority.
  function automatic slot_res_t classify(
    input logic        vld,
    input logic [31:0] pc,
    input logic        invalid,
    input logic        sys,
    input logic        brk,
    input logic        ov,
    input logic        load,
    input logic        store,
    input logic [1:0]  size,
    input logic [31:0] addr,
    input logic        eret,
    input logic        mfc0,
    input logic        mtc0,
    input logic [4:0]  cp0a,
    input logic        ds
  );
    slot_res_t r;
    logic      mis;
    r   = '0;
    // Size 11 falls into the word case via size[1].
    mis = (size == 2'b01) ? addr[0] : (size[1] ? (addr[1:0] != 2'b00) : 1'b0);
    if (vld) begin
      r.info[10] = ds;
      if (pc[1:0] != 2'b00) begin
        r.info[9] = 1'b1;
        r.bad     = pc;
      end else if (invalid) begin
        r.info[3] = 1'b1;
      end else if (sys) begin
        r.info[5] = 1'b1;
      end else if (brk) begin
        r.info[4] = 1'b1;
      end else if (ov) begin
        r.info[6] = 1'b1;
      end else if (load && mis) begin
        r.info[7] = 1'b1;
        r.bad     = addr;
      end else if (store && mis) begin
        r.info[8] = 1'b1;
        r.bad     = addr;
      end
      r.exc  = |r.info[9:3];
      r.eret = eret;
      // A faulting instruction never reaches CP0 as eret/mfc0/mtc0.
      if (!r.exc) begin
        r.info[2] = eret;
        r.info[1] = mfc0;
        r.info[0] = mtc0;
        if (mfc0 || mtc0) r.info[15:11] = cp0a;
      end
    end
    return r;
  endfunction

  state_t                   state_q, state_d;
  logic [2:0]               cnt_q, cnt_d;
  logic                     pending_ds_q, pending_ds_d;
  logic [EXCEPTINFO_WD-1:0] info1_q, info1_d, info2_q, info2_d;
  logic [31:0]              pc1_q, pc1_d, pc2_q, pc2_d;
  logic [31:0]              rt1_q, rt1_d, rt2_q, rt2_d;
  logic [31:0]              bad1_q, bad1_d, bad2_q, bad2_d;
  logic                     commit1_q, commit1_d, commit2_q, commit2_d;

  slot_res_t s1, s2;
  logic      accept;
  logic      squash2;

  // Per-slot classification and the accept/squash qualifiers.
  always_comb begin
    s1 = classify(valid_i1, pc_i1, invalid_i1, syscall_i1, break_i1, overflow_i1,
                  mem_load_i1, mem_store_i1, mem_size_i1, mem_addr_i1,
                  eret_i1, mfc0_i1, mtc0_i1, cp0_addr_i1, pending_ds_q);
    s2 = classify(valid_i2, pc_i2, invalid_i2, syscall_i2, break_i2, overflow_i2,
                  mem_load_i2, mem_store_i2, mem_size_i2, mem_addr_i2,
                  eret_i2, mfc0_i2, mtc0_i2, cp0_addr_i2, valid_i1 & is_branch_i1);
    accept  = (state_q == RUN) && !stall_i && !flush_i;
    // Slot 2 is younger: anything that redirects slot 1 kills it.
    squash2 = s1.exc | s1.eret;
  end

  // Next-state for output registers, delay-slot tracking and the squash FSM.
  always_comb begin
    info1_d      = '0;
    info2_d      = '0;
    bad1_d       = '0;
    bad2_d       = '0;
    commit1_d    = 1'b0;
    commit2_d    = 1'b0;
    pc1_d        = pc1_q;
    pc2_d        = pc2_q;
    rt1_d        = rt1_q;
    rt2_d        = rt2_q;
    pending_ds_d = pending_ds_q;
    state_d      = state_q;
    cnt_d        = cnt_q;

    if (accept) begin
      info1_d   = s1.info;
      bad1_d    = s1.bad;
      pc1_d     = pc_i1;
      rt1_d     = rt_rdata_i1;
      commit1_d = valid_i1 & ~s1.exc & ~eret_i1;
      if (squash2) begin
        pc2_d = '0;
        rt2_d = '0;
      end else begin
        info2_d   = s2.info;
        bad2_d    = s2.bad;
        pc2_d     = pc_i2;
        rt2_d     = rt_rdata_i2;
        commit2_d = valid_i2 & ~s2.exc & ~eret_i2;
      end
      // The youngest valid instruction decides whether next cycle's slot 1 is a delay slot.
      if (s1.exc || s1.eret || s2.exc || s2.eret) pending_ds_d = 1'b0;
      else if (valid_i2)                          pending_ds_d = is_branch_i2;
      else if (valid_i1)                          pending_ds_d = is_branch_i1;
    end

    if (flush_i) begin
      pending_ds_d = 1'b0;
      state_d      = SQUASH;
      cnt_d        = FLUSH_CNT;
    end else if (state_q == SQUASH) begin
      // Stall does not hold the counter: the window is wall-clock cycles.
      if (cnt_q <= 3'd1) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end
  end

  // State and output registers, cleared immediately by the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      pending_ds_q <= 1'b0;
      info1_q      <= '0;
      info2_q      <= '0;
      pc1_q        <= '0;
      pc2_q        <= '0;
      rt1_q        <= '0;
      rt2_q        <= '0;
      bad1_q       <= '0;
      bad2_q       <= '0;
      commit1_q    <= 1'b0;
      commit2_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_ds_q <= pending_ds_d;
      info1_q      <= info1_d;
      info2_q      <= info2_d;
      pc1_q        <= pc1_d;
      pc2_q        <= pc2_d;
      rt1_q        <= rt1_d;
      rt2_q        <= rt2_d;
      bad1_q       <= bad1_d;
      bad2_q       <= bad2_d;
      commit1_q    <= commit1_d;
      commit2_q    <= commit2_d;
    end
  end

  assign exceptinfo_o1 = info1_q;
  assign exceptinfo_o2 = info2_q;
  assign current_pc_o1 = pc1_q;
  assign current_pc_o2 = pc2_q;
  assign rt_rdata_o1   = rt1_q;
  assign rt_rdata_o2   = rt2_q;
  assign bad_addr_o1   = bad1_q;
  assign bad_addr_o2   = bad2_q;
  assign commit_o1     = commit1_q;
  assign commit_o2     = commit2_q;

endmodule

// File: tb/tb_exc_info_gen.sv
// Directed bench for exc_info_gen: one task per scenario, inline expected values.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// The design has no backpressure of its own; stall/flush are driven as stimulus.
module tb_exc_info_gen;

  logic        clk, rst, stall_i, flush_i;
  logic        valid_i1, valid_i2, is_branch_i1, is_branch_i2;
  logic [31:0] pc_i1, pc_i2, mem_addr_i1, mem_addr_i2, rt_rdata_i1, rt_rdata_i2;
  logic        syscall_i1, syscall_i2, break_i1, break_i2, invalid_i1, invalid_i2;
  logic        eret_i1, eret_i2, mfc0_i1, mfc0_i2, mtc0_i1, mtc0_i2;
  logic [4:0]  cp0_addr_i1, cp0_addr_i2;
  logic        overflow_i1, overflow_i2, mem_load_i1, mem_load_i2, mem_store_i1, mem_store_i2;
  logic [1:0]  mem_size_i1, mem_size_i2;
  logic [15:0] ei1, ei2;
  logic [31:0] pc1, pc2, rt1, rt2, bad1, bad2;
  logic        c1, c2;

  int tests = 0;
  int fails = 0;

  exc_info_gen #(.EXCEPTINFO_WD(16), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i1(valid_i1), .valid_i2(valid_i2), .pc_i1(pc_i1), .pc_i2(pc_i2),
    .is_branch_i1(is_branch_i1), .is_branch_i2(is_branch_i2),
    .syscall_i1(syscall_i1), .syscall_i2(syscall_i2), .break_i1(break_i1), .break_i2(break_i2),
    .invalid_i1(invalid_i1), .invalid_i2(invalid_i2), .eret_i1(eret_i1), .eret_i2(eret_i2),
    .mfc0_i1(mfc0_i1), .mfc0_i2(mfc0_i2), .mtc0_i1(mtc0_i1), .mtc0_i2(mtc0_i2),
    .cp0_addr_i1(cp0_addr_i1), .cp0_addr_i2(cp0_addr_i2),
    .overflow_i1(overflow_i1), .overflow_i2(overflow_i2),
    .mem_load_i1(mem_load_i1), .mem_load_i2(mem_load_i2),
    .mem_store_i1(mem_store_i1), .mem_store_i2(mem_store_i2),
    .mem_size_i1(mem_size_i1), .mem_size_i2(mem_size_i2),
    .mem_addr_i1(mem_addr_i1), .mem_addr_i2(mem_addr_i2),
    .rt_rdata_i1(rt_rdata_i1), .rt_rdata_i2(rt_rdata_i2),
    .exceptinfo_o1(ei1), .exceptinfo_o2(ei2), .current_pc_o1(pc1), .current_pc_o2(pc2),
    .rt_rdata_o1(rt1), .rt_rdata_o2(rt2), .bad_addr_o1(bad1), .bad_addr_o2(bad2),
    .commit_o1(c1), .commit_o2(c2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr();
    stall_i = 0; flush_i = 0;
    valid_i1 = 0; valid_i2 = 0; is_branch_i1 = 0; is_branch_i2 = 0;
    pc_i1 = '0; pc_i2 = '0; mem_addr_i1 = '0; mem_addr_i2 = '0;
    rt_rdata_i1 = '0; rt_rdata_i2 = '0;
    syscall_i1 = 0; syscall_i2 = 0; break_i1 = 0; break_i2 = 0;
    invalid_i1 = 0; invalid_i2 = 0; eret_i1 = 0; eret_i2 = 0;
    mfc0_i1 = 0; mfc0_i2 = 0; mtc0_i1 = 0; mtc0_i2 = 0;
    cp0_addr_i1 = '0; cp0_addr_i2 = '0; overflow_i1 = 0; overflow_i2 = 0;
    mem_load_i1 = 0; mem_load_i2 = 0; mem_store_i1 = 0; mem_store_i2 = 0;
    mem_size_i1 = '0; mem_size_i2 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr();
    repeat (2) tick();
    tests++; if (ei1 !== 16'h0 || ei2 !== 16'h0) begin fails++; $display("FAIL reset_ei got %h/%h exp 0000/0000", ei1, ei2); end
    tests++; if ({c1, c2} !== 2'b00) begin fails++; $display("FAIL reset_commit got %b exp 00", {c1, c2}); end
    tests++; if ({pc1, pc2, rt1, rt2, bad1, bad2} !== '0) begin fails++; $display("FAIL reset_data got nonzero exp 0"); end
    rst = 1'b0;
  endtask

  task automatic test_adel();
    clr();
    valid_i1 = 1; pc_i1 = 32'hBFC00010; mem_load_i1 = 1; mem_size_i1 = 2'b10; mem_addr_i1 = 32'h1002;
    valid_i2 = 1; pc_i2 = 32'hBFC00014;
    tick();
    tests++; if (ei1 !== 16'h0080) begin fails++; $display("FAIL adel_ei1 got %h exp 0080", ei1); end
    tests++; if (bad1 !== 32'h00001002) begin fails++; $display("FAIL adel_bad1 got %h exp 00001002", bad1); end
    tests++; if (ei2 !== 16'h0) begin fails++; $display("FAIL adel_ei2 got %h exp 0000", ei2); end
    tests++; if ({c1, c2} !== 2'b00) begin fails++; $display("FAIL adel_commit got %b exp 00", {c1, c2}); end
    tests++; if (pc1 !== 32'hBFC00010) begin fails++; $display("FAIL adel_pc1 got %h exp bfc00010", pc1); end
  endtask

  task automatic test_ds_ades();
    clr();
    valid_i1 = 1; pc_i1 = 32'h100; is_branch_i1 = 1;
    valid_i2 = 1; pc_i2 = 32'h104; mem_store_i2 = 1; mem_size_i2 = 2'b01; mem_addr_i2 = 32'h2001;
    tick();
    tests++; if (ei2 !== 16'h0500) begin fails++; $display("FAIL ades_ei2 got %h exp 0500", ei2); end
    tests++; if (bad2 !== 32'h2001) begin fails++; $display("FAIL ades_bad2 got %h exp 00002001", bad2); end
    tests++; if ({ei1, c1, c2} !== {16'h0, 2'b10}) begin fails++; $display("FAIL ades_slot1 got %h %b%b exp 0000 10", ei1, c1, c2); end
  endtask

  task automatic test_ds_cross();
    clr();
    valid_i1 = 1; pc_i1 = 32'h1F0; is_branch_i1 = 1;
    tick();
    tests++; if ({ei1, c1} !== {16'h0, 1'b1}) begin fails++; $display("FAIL jr_slot1 got %h %b exp 0000 1", ei1, c1); end
    clr();
    valid_i1 = 1; pc_i1 = 32'h200; syscall_i1 = 1;
    tick();
    tests++; if (ei1 !== 16'h0420) begin fails++; $display("FAIL ds_sys_ei1 got %h exp 0420", ei1); end
    tests++; if (pc1 !== 32'h200 || c1 !== 1'b0) begin fails++; $display("FAIL ds_sys_pc got %h c%b exp 00000200 c0", pc1, c1); end
  endtask

  task automatic test_pcaddr();
    clr();
    valid_i1 = 1; pc_i1 = 32'h102; invalid_i1 = 1; syscall_i1 = 1;
    tick();
    tests++; if (ei1 !== 16'h0200) begin fails++; $display("FAIL pcaddr_ei1 got %h exp 0200", ei1); end
    tests++; if (bad1 !== 32'h102) begin fails++; $display("FAIL pcaddr_bad1 got %h exp 00000102", bad1); end
  endtask

  task automatic test_cp0_mask();
    clr();
    valid_i1 = 1; pc_i1 = 32'h300; mfc0_i1 = 1; cp0_addr_i1 = 5'd9;
    valid_i2 = 1; pc_i2 = 32'h304; mtc0_i2 = 1; cp0_addr_i2 = 5'd12; overflow_i2 = 1;
    tick();
    tests++; if (ei1 !== 16'h4802) begin fails++; $display("FAIL mfc0_ei1 got %h exp 4802", ei1); end
    tests++; if (ei2 !== 16'h0040) begin fails++; $display("FAIL ov_mask_ei2 got %h exp 0040", ei2); end
    tests++; if ({c1, c2} !== 2'b10) begin fails++; $display("FAIL cp0_commit got %b exp 10", {c1, c2}); end
  endtask

  task automatic test_eret_squash();
    clr();
    valid_i1 = 1; pc_i1 = 32'h400; eret_i1 = 1;
    valid_i2 = 1; pc_i2 = 32'h404; rt_rdata_i2 = 32'h55;
    tick();
    tests++; if (ei1 !== 16'h0004 || c1 !== 1'b0) begin fails++; $display("FAIL eret_slot1 got %h c%b exp 0004 c0", ei1, c1); end
    tests++; if ({ei2, c2, pc2, rt2} !== '0) begin fails++; $display("FAIL eret_squash2 got %h c%b pc %h exp all 0", ei2, c2, pc2); end
  endtask

  task automatic test_stall();
    clr();
    valid_i1 = 1; pc_i1 = 32'h4F0; is_branch_i1 = 1;
    tick();
    clr();
    stall_i = 1; valid_i1 = 1; pc_i1 = 32'h4F4; syscall_i1 = 1;
    tick();
    tests++; if ({ei1, c1, bad1} !== '0) begin fails++; $display("FAIL stall_bubble got %h c%b exp 0000 c0", ei1, c1); end
    stall_i = 0;
    tick();
    tests++; if (ei1 !== 16'h0420) begin fails++; $display("FAIL stall_ds_hold got %h exp 0420", ei1); end
  endtask

  task automatic test_flush();
    clr();
    valid_i1 = 1; pc_i1 = 32'h4FC; is_branch_i1 = 1;
    tick();
    clr();
    flush_i = 1; valid_i1 = 1; pc_i1 = 32'h500;
    for (int k = 0; k < 3; k++) begin
      tick();
      clr();
      valid_i1 = 1; pc_i1 = 32'h504; mtc0_i1 = 1; cp0_addr_i1 = 5'd12;
      tests++; if ({ei1, ei2, c1, c2} !== '0) begin fails++; $display("FAIL flush_bubble%0d got %h %b exp 0000 0", k, ei1, c1); end
    end
    tick();
    tests++; if (ei1 !== 16'h6001 || c1 !== 1'b1) begin fails++; $display("FAIL flush_resume got %h c%b exp 6001 c1", ei1, c1); end
  endtask

  task automatic test_flush_reload();
    clr();
    flush_i = 1; stall_i = 1; valid_i1 = 1; pc_i1 = 32'h700; syscall_i1 = 1;
    tick();
    stall_i = 0;
    tick();
    flush_i = 0; stall_i = 1;
    tick();
    stall_i = 0;
    tick();
    tests++; if ({ei1, c1} !== '0) begin fails++; $display("FAIL reload_bubble got %h c%b exp 0000 c0", ei1, c1); end
    tick();
    tests++; if (ei1 !== 16'h0020) begin fails++; $display("FAIL reload_resume got %h exp 0020", ei1); end
  endtask

  task automatic test_async_reset();
    clr();
    valid_i1 = 1; pc_i1 = 32'h5F0; is_branch_i1 = 1; rt_rdata_i1 = 32'hAB;
    tick();
    tests++; if (c1 !== 1'b1 || pc1 !== 32'h5F0) begin fails++; $display("FAIL arst_pre got c%b pc %h exp c1 000005f0", c1, pc1); end
    #3 rst = 1'b1;
    #1;
    tests++; if ({c1, pc1, rt1} !== '0) begin fails++; $display("FAIL arst_clear got c%b pc %h rt %h exp 0", c1, pc1, rt1); end
    tick();
    rst = 1'b0;
    clr();
    valid_i1 = 1; pc_i1 = 32'h600; syscall_i1 = 1;
    tick();
    tests++; if (ei1 !== 16'h0020) begin fails++; $display("FAIL arst_ds_cleared got %h exp 0020", ei1); end
  endtask

  initial begin
    test_reset();
    test_adel();
    test_ds_ades();
    test_ds_cross();
    test_pcaddr();
    test_cp0_mask();
    test_eret_squash();
    test_stall();
    test_flush();
    test_flush_reload();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exc_info_gen.md
Name: exc_info_gen

Overview:
- MEM-stage exception packer for the dual-issue pipeline; the producer side of the CP0 exception interface.
- Each cycle it takes up to two issuing instructions (slot 1 older) and classifies their exceptions with MIPS priority.
- It tracks branch delay slots across cycles, squashes younger and wrong-path work, and registers one 16-bit exceptinfo word per slot plus pc, rt data and bad address into CP0.
- It also produces per-slot commit enables for writeback.

Parameters:
- EXCEPTINFO_WD, 16: width of each exceptinfo word.
- FLUSH_CYCLES, 2: cycles of wrong-path suppression after flush_i; legal range 1-7.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- stall_i  in  1  pipeline stall; inputs are not consumed this cycle
- flush_i  in  1  CP0 to_be_flushed
- valid_i1/valid_i2  in  1  slot has an instruction
- pc_i1/pc_i2  in  32  instruction pc
- is_branch_i1/_i2  in  1  branch or jump
- syscall_i*/break_i*/invalid_i*/eret_i*/mfc0_i*/mtc0_i*  in  1 each  decode flags
- cp0_addr_i1/_i2  in  5  rd field of mfc0/mtc0
- overflow_i1/_i2  in  1  ALU overflow
- mem_load_i*/mem_store_i*  in  1  memory op
- mem_size_i1/_i2  in  2  00 byte, 01 half, 10 word
- mem_addr_i1/_i2  in  32  effective address
- rt_rdata_i1/_i2  in  32  rt value
- exceptinfo_o1/_o2  out  16  {addr[15:11], ds[10], pcaddr[9], ades[8], adel[7], ov[6], sys[5], brk[4], ri[3], eret[2], mfc0[1], mtc0[0]}
- current_pc_o1/_o2  out  32
- rt_rdata_o1/_o2  out  32
- bad_addr_o1/_o2  out  32
- commit_o1/_o2  out  1  slot may write registers / memory

Behaviour:
- All outputs are registered with 1-cycle latency. Every output resets to 0.
- Internal reset state: pending_ds=0, FSM=RUN, squash counter=0.
- Accepted cycle: FSM==RUN, !stall_i, !flush_i.
- Non-accepted cycle: all exceptinfo_o*, commit_o* and bad_addr_o* are 0 (bubble). pc and rt outputs may hold.
- Per-slot priority, highest first; exactly one of bits 9:3 is set:
  - pcaddr: pc[1:0]!=0; bad_addr=pc.
  - ri (bit 3).
  - sys (bit 5), then brk (bit 4).
  - ov (bit 6).
  - adel: load with half and addr[0], or word and addr[1:0]!=0; bad_addr=mem_addr.
  - ades: the same test for stores; bad_addr=mem_addr.
  - Size 11 is treated as word.
- Any exception in a slot masks eret/mfc0/mtc0 bits to 0 for that slot. With no exception, these bits pass through. Bits 15:11 = cp0_addr when mfc0|mtc0, else 0.
- Invalid slot gives an all-zero word.
- Delay-slot bit:
  - slot1 ds = pending_ds.
  - slot2 ds = valid_i1 & is_branch_i1.
- pending_ds update, accepted cycles only:
  - valid_i2 → is_branch_i2.
  - valid_i1 only → is_branch_i1.
  - neither valid → hold.
  - An exception or eret in any slot → 0.
- Slot2 squash: if slot1 has any exception or eret, slot2 outputs are all 0 and commit_o2=0.
- Commit: commit_o1 = valid & no exception & !eret. commit_o2 additionally requires slot2 not squashed.
- FSM:
  - RUN→SQUASH on flush_i. Counter loads FLUSH_CYCLES, and pending_ds clears the same cycle.
  - SQUASH decrements the counter each cycle and returns to RUN when the counter reaches 1.
  - flush_i while in SQUASH reloads the counter.
  - stall_i does not pause the counter.
- Simultaneous flush_i and stall_i: flush wins.
- Async rst mid-operation clears everything immediately.

Test Plan:
- Slot1 lw, addr 0x1002, pc 0xBFC00010; slot2 add → next cycle exceptinfo_o1=0x0080, bad_addr_o1=0x00001002, exceptinfo_o2=0, commit_o1=0, commit_o2=0.
- Slot1 beq (pc 0x100), slot2 sw half at addr 0x2001 → o2 bits 10 and 8 set (0x0500), bad_addr_o2=0x2001, commit_o1=1.
- Cycle N: slot1 only, jr. Cycle N+1: slot1 syscall, pc 0x200 → exceptinfo_o1=0x0420, current_pc_o1=0x200.
- Slot1 pc 0x102 flagged invalid and syscall → only bit 9 set (0x0200), bad_addr_o1=0x102.
- flush_i for 1 cycle with valid traffic, FLUSH_CYCLES=2 → outputs are 0 for 3 cycles (flush + 2 squash), then the first valid mtc0 addr 12 gives 0x6001.
- Assert rst asynchronously mid-stream → all outputs 0 before the next clk edge; pending_ds=0 afterwards.
